// File: rtl/reg_write_sequencer_if.sv
// Bundle between the instruction byte source, the sequencer and register_bank.
// "slave" is the sequencer's view; "master" is the byte source plus bank side.
interface reg_write_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
);
    logic [7:0]            instr_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] rb_data_in;
    logic [SEL_WIDTH-1:0]  rb_reg_sel;
    logic                  rb_en;
    logic [DATA_WIDTH-1:0] rb_data_out;
    logic                  busy;
    logic                  halted;
    logic                  illegal;

    modport slave (
        input  instr_data, instr_valid, rb_data_out,
        output instr_ready, rb_data_in, rb_reg_sel, rb_en, busy, halted, illegal
    );

    modport master (
        output instr_data, instr_valid, rb_data_out,
        input  instr_ready, rb_data_in, rb_reg_sel, rb_en, busy, halted, illegal
    );
endinterface

// File: rtl/reg_write_sequencer.sv
// Decodes a byte stream of register-transfer instructions and drives register_bank.
// Define ARITH_OPS_EN to execute INC/DEC; otherwise those opcodes decode as illegal.
module reg_write_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_write_sequencer_if.slave  bus
);

`ifdef ARITH_OPS_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_OPERAND,
        S_READ,
        S_WRITE,
        S_HALT
    } state_t;

    state_t                r_state, w_state_next;
    logic [2:0]            r_op, w_op_next;
    logic [SEL_WIDTH-1:0]  r_rd, w_rd_next;
    logic [SEL_WIDTH-1:0]  r_sel, w_sel_next;
    logic [DATA_WIDTH-1:0] r_din, w_din_next;
    logic                  r_en, w_en_next;
    logic                  r_halted, w_halted_next;
    logic                  r_illegal, w_illegal_next;

    logic                  w_ready;
    logic                  w_accept;
    logic [2:0]            w_opc;
    logic [SEL_WIDTH-1:0]  w_opc_rd;

    assign w_ready  = ((r_state == S_FETCH) || (r_state == S_OPERAND)) && !rst;
    assign w_accept = bus.instr_valid && w_ready;
    assign w_opc    = bus.instr_data[7:5];
    assign w_opc_rd = SEL_WIDTH'(bus.instr_data[4:2]);

    // Bank outputs are registered: each arm sets what the bank sees in the next state.
    always_comb begin
        w_state_next   = r_state;
        w_op_next      = r_op;
        w_rd_next      = r_rd;
        w_sel_next     = r_sel;
        w_din_next     = r_din;
        w_en_next      = 1'b0;
        w_halted_next  = r_halted;
        w_illegal_next = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_op_next = w_opc;
                    w_rd_next = w_opc_rd;
                    case (w_opc)
                        OP_NOP: ;
                        OP_LDI, OP_MOV: w_state_next = S_OPERAND;
                        OP_INC, OP_DEC: begin
                            if (ARITH_EN) begin
                                w_state_next = S_READ;
                                w_sel_next   = w_opc_rd;
                            end else begin
                                w_illegal_next = 1'b1;
                            end
                        end
                        OP_CLR: begin
                            w_state_next = S_WRITE;
                            w_sel_next   = w_opc_rd;
                            w_din_next   = '0;
                            w_en_next    = 1'b1;
                        end
                        OP_HLT: begin
                            w_state_next  = S_HALT;
                            w_halted_next = 1'b1;
                        end
                        default: w_illegal_next = 1'b1;
                    endcase
                end
            end
            S_OPERAND: begin
                if (w_accept) begin
                    if (r_op == OP_MOV) begin
                        w_state_next = S_READ;
                        w_sel_next   = SEL_WIDTH'(bus.instr_data[2:0]);
                    end else begin
                        w_state_next = S_WRITE;
                        w_sel_next   = r_rd;
                        w_din_next   = DATA_WIDTH'(bus.instr_data);
                        w_en_next    = 1'b1;
                    end
                end
            end
            S_READ: begin
                // rb_reg_sel already points at the source, so data_out is valid now.
                w_state_next = S_WRITE;
                w_sel_next   = r_rd;
                w_en_next    = 1'b1;
                case (r_op)
                    OP_INC:  w_din_next = bus.rb_data_out + DATA_WIDTH'(1);
                    OP_DEC:  w_din_next = bus.rb_data_out - DATA_WIDTH'(1);
                    default: w_din_next = bus.rb_data_out;
                endcase
            end
            S_WRITE: w_state_next = S_FETCH;
            S_HALT:  w_halted_next = 1'b1;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= OP_NOP;
            r_rd      <= '0;
            r_sel     <= '0;
            r_din     <= '0;
            r_en      <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_op      <= w_op_next;
            r_rd      <= w_rd_next;
            r_sel     <= w_sel_next;
            r_din     <= w_din_next;
            r_en      <= w_en_next;
            r_halted  <= w_halted_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.busy        = (r_state == S_OPERAND) || (r_state == S_READ) || (r_state == S_WRITE);
    assign bus.rb_data_in  = r_din;
    assign bus.rb_reg_sel  = r_sel;
    assign bus.rb_en       = r_en;
    assign bus.halted      = r_halted;
    assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench: cycle-by-cycle vector table plus hand-written halt/abort/stall
// sequences, with a small register_bank model behind the sequencer.
module tb_reg_write_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_sequencer_if #(.DATA_WIDTH(8), .SEL_WIDTH(3)) bus ();

    reg_write_sequencer #(.DATA_WIDTH(8), .SEL_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // register_bank model: combinational read, write on en; not cleared by rst
    logic [7:0] bank [8] = '{default: 8'h00};
    int         en_count = 0;
    assign bus.rb_data_out = bank[bus.rb_reg_sel];
    always @(posedge clk) begin
        if (bus.rb_en) begin
            bank[bus.rb_reg_sel] <= bus.rb_data_in;
            en_count <= en_count + 1;
        end
    end

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic [15:0] exp;  // {ready, busy, en, halted, illegal, sel[2:0], din[7:0]}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic rdy, input logic bsy, input logic en,
                                input logic [2:0] sel, input logic [7:0] din,
                                input logic hlt, input logic ill);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.data  = d;
        t.exp   = {rdy, bsy, en, hlt, ill, sel, din};
        return t;
    endfunction

    function automatic logic [15:0] outs();
        return {bus.instr_ready, bus.busy, bus.rb_en, bus.halted, bus.illegal,
                bus.rb_reg_sel, bus.rb_data_in};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        rst             = r;
        bus.instr_valid = v;
        bus.instr_data  = d;
    endtask

    int snap;

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;

        //        rst v  data   rdy bsy en sel din   hlt ill
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h2C, 1, 1, 0, 0, 8'h00, 0, 0)); // LDI R3
        vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1, 3, 8'h55, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 3, 8'h55, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 1, 1, 0, 3, 8'h55, 0, 0)); // LDI R0
        vecs.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 0, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 8'h5C, 1, 1, 0, 0, 8'hAA, 0, 0)); // MOV R7,R0
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 7, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 7, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 8'hC0, 1, 0, 0, 7, 8'hAA, 0, 1)); // illegal
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 7, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 8'h90, 0, 1, 1, 4, 8'h00, 0, 0)); // CLR R4
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 4, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h24, 1, 1, 0, 4, 8'h00, 0, 0)); // LDI R1
        vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 1, 1, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
`ifdef ARITH_OPS_EN
        vecs.push_back(mk(0, 1, 8'h64, 0, 1, 0, 1, 8'hFF, 0, 0)); // INC R1
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 0, 1, 0, 1, 8'h00, 0, 0)); // DEC R1
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
`else
        vecs.push_back(mk(0, 1, 8'h64, 1, 0, 0, 1, 8'hFF, 0, 1)); // INC -> illegal
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 1, 0, 0, 1, 8'hFF, 0, 1)); // DEC -> illegal
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data);
            tick();
            check($sformatf("vec[%0d] rdy/bsy/en/hlt/ill/sel/din", i), 32'(outs()), 32'(vecs[i].exp));
        end
        drive(0, 0, 8'h00);

        check("bank R3", 32'(bank[3]), 32'h55);
        check("bank R0", 32'(bank[0]), 32'hAA);
        check("bank R7", 32'(bank[7]), 32'hAA);
        check("bank R4", 32'(bank[4]), 32'h00);
        check("bank R1", 32'(bank[1]), 32'hFF);
`ifdef ARITH_OPS_EN
        check("write count after table", 32'(en_count), 32'd7);
`else
        check("write count after table", 32'(en_count), 32'd5);
`endif

        // HLT with valid held high: ready stays low, no writes, until rst
        snap = en_count;
        drive(0, 1, 8'hE0);
        tick();
        check("hlt rdy/bsy/en/hlt/ill/sel/din", 32'(outs()), 32'(mk(0,0,0, 0,0,0,1,8'hFF,1,0).exp));
        drive(0, 1, 8'h2C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("halted hold[%0d]", i), 32'(outs()), 32'(mk(0,0,0, 0,0,0,1,8'hFF,1,0).exp));
        end
        check("no write while halted", 32'(en_count), 32'(snap));
        drive(1, 1, 8'h2C);
        tick();
        check("rst clears halt", 32'(outs()), 32'(mk(0,0,0, 0,0,0,0,8'h00,0,0).exp));
        drive(0, 0, 8'h00);
        tick();
        check("ready after halt rst", 32'(outs()), 32'(mk(0,0,0, 1,0,0,0,8'h00,0,0).exp));

        // rst in OPERAND of LDI R2 aborts without a write
        snap = en_count;
        drive(0, 1, 8'h28);
        tick();
        check("ldi r2 operand busy", 32'(bus.busy), 32'd1);
        drive(1, 1, 8'h77);
        tick();
        drive(0, 0, 8'h00);
        tick();
        tick();
        check("abort: no write", 32'(en_count), 32'(snap));
        check("abort: R2 untouched", 32'(bank[2]), 32'h00);

        // valid low for 5 cycles between LDI bytes: wait, then one write
        drive(0, 1, 8'h28);
        tick();
        drive(0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("operand wait[%0d]", i), 32'(outs()), 32'(mk(0,0,0, 1,1,0,0,8'h00,0,0).exp));
        end
        drive(0, 1, 8'h3C);
        tick();
        check("stalled ldi write", 32'(outs()), 32'(mk(0,0,0, 0,1,1,2,8'h3C,0,0).exp));
        drive(0, 0, 8'h00);
        tick();
        tick();
        check("stalled ldi single write", 32'(en_count), 32'(snap + 1));
        check("bank R2", 32'(bank[2]), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
